pipe_debug_ctrl: RTL

//  Sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) under debug-unit control.

---
 rtl/pipe_debug_pkg.sv | 26 ++
 rtl/pipe_cycle_counter.sv | 34 +++
 rtl/pipe_debug_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_debug_pkg.sv
// Shared encodings for the pipeline debug sequencer: debug commands, FSM states and step-count helpers.
package pipe_debug_pkg;

  localparam int unsigned STEP_W = 8;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_HALT  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A STEP of zero cycles still executes one cycle.
  function automatic logic [STEP_W-1:0] step_load(input logic [STEP_W-1:0] n);
    return (n == '0) ? STEP_W'(1) : n;
  endfunction

endpackage

// File: rtl/pipe_cycle_counter.sv
// Saturating up-counter with enable and synchronous clear (clear wins over enable).
module pipe_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_debug_ctrl.sv
// Debug-unit sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB registers: run/step/clear/halt
// control, hazard-driven stall/flush decode and an executed-cycle counter.
module pipe_debug_ctrl
  import pipe_debug_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] stepN,
  input  logic              eopWb,
  input  logic              loadUseHazard,
  input  logic              branchTaken,
  output logic              debugEnable,
  output logic              debugReset,
  output logic              pcWrite,
  output logic              ifIdWrite,
  output logic              ifIdSyncClr,
  output logic              idExSyncClr,
  output logic              running,
  output logic              done,
  output logic              stepDone,
  output logic [CNT_W-1:0]  cycleCount
);

  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              debug_enable_q, debug_enable_d;
  logic              debug_reset_q, debug_reset_d;
  logic              done_q, done_d;
  logic              step_done_q, step_done_d;
  logic              cmd_fire;
  logic              cnt_clr;
  cmd_e              cmd_w;

  assign cmd_w    = cmd_e'(cmd);
  assign cmd_fire = cmdValid && cmd_ready_q;

  // Next state, step/clear down-counters and the registered state decodes.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    clr_d       = clr_q;
    step_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (cmd_w)
            CMD_RUN:   state_d = ST_RUN;
            CMD_STEP: begin
              state_d = ST_STEP;
              rem_d   = step_load(stepN);
            end
            CMD_CLEAR: begin
              state_d = ST_CLEAR;
              clr_d   = CLR_W'(CLR_CYCLES);
            end
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        // End of program outranks a HALT offered in the same cycle.
        if (eopWb) begin
          state_d = ST_DONE;
        end else if (cmd_fire && (cmd_w == CMD_HALT)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (eopWb) begin
          state_d     = ST_DONE;
          rem_d       = '0;
          step_done_d = 1'b1;
        end else if (rem_q <= STEP_W'(1)) begin
          state_d     = ST_IDLE;
          rem_d       = '0;
          step_done_d = 1'b1;
        end else begin
          rem_d = rem_q - STEP_W'(1);
        end
      end
      ST_CLEAR: begin
        if (clr_q <= CLR_W'(1)) begin
          state_d = ST_IDLE;
          clr_d   = '0;
        end else begin
          clr_d = clr_q - CLR_W'(1);
        end
      end
      ST_DONE: begin
        if (cmd_fire && (cmd_w == CMD_CLEAR)) begin
          state_d = ST_CLEAR;
          clr_d   = CLR_W'(CLR_CYCLES);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d    = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_DONE);
    debug_enable_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    debug_reset_d  = (state_d == ST_CLEAR);
    done_d         = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rem_q          <= '0;
      clr_q          <= '0;
      cmd_ready_q    <= 1'b1;
      debug_enable_q <= 1'b0;
      debug_reset_q  <= 1'b0;
      done_q         <= 1'b0;
      step_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      clr_q          <= clr_d;
      cmd_ready_q    <= cmd_ready_d;
      debug_enable_q <= debug_enable_d;
      debug_reset_q  <= debug_reset_d;
      done_q         <= done_d;
      step_done_q    <= step_done_d;
    end
  end

  // Counter is zeroed throughout CLEAR, starting on the entry edge.
  assign cnt_clr = (state_d == ST_CLEAR);

  pipe_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clock (clock),
    .reset (reset),
    .en    (debug_enable_q),
    .clr   (cnt_clr),
    .count (cycleCount)
  );

  // Hazard decode: load-use stall outranks a taken branch.
  always_comb begin
    pcWrite     = 1'b0;
    ifIdWrite   = 1'b0;
    ifIdSyncClr = 1'b0;
    idExSyncClr = 1'b0;
    if (debug_enable_q) begin
      if (loadUseHazard) begin
        idExSyncClr = 1'b1;
      end else if (branchTaken) begin
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        ifIdSyncClr = 1'b1;
      end else begin
        pcWrite   = 1'b1;
        ifIdWrite = 1'b1;
      end
    end
  end

  assign cmdReady    = cmd_ready_q;
  assign debugEnable = debug_enable_q;
  assign debugReset  = debug_reset_q;
  assign running     = debug_enable_q;
  assign done        = done_q;
  assign stepDone    = step_done_q;

endmodule
